gate_resp_checker: RTL and testbench
====================================

# gate_resp_checker

Synthesizable response checker for 2-input gate tests: consumes a stream of (a, b, result) samples from a gate under test and compares each result against a parameterised truth table. It counts samples and mismatches, tracks which input combinations were covered, captures the first failing vector, and reports pass/fail once a programmed number of samples has been accepted. It sits at the observing end of the gate stimulus path and replaces `$monitor`-style manual inspection with hardware verdicts.

## Interface
- `TRUTH_TABLE`, 4'b1000: expected result indexed by {a,b}; the default is AND.
- `N_SAMPLES`, 4: number of samples per run, 1..2^CNT_W-1.
- `CNT_W`, 8: width of the sample and error counters.
- `TIMEOUT`, 64: idle-cycle limit for the watchdog (see Configuration).

- `clk`  in  1  single clock; all logic rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse that begins a run.
- `smp_valid`  in  1  sample present.
- `smp_ready`  out  1  checker accepts sample.
- `smp_a`, `smp_b`  in  1 each  gate inputs applied.
- `smp_c`  in  1  gate result observed.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished; held until next `start`.
- `pass`  out  1  valid when `done`.
- `timeout`  out  1  run ended by watchdog.
- `smp_cnt`  out  CNT_W  samples accepted this run.
- `err_cnt`  out  CNT_W  mismatches this run.
- `cov`  out  4  bit {a,b} set when that combination was seen.
- `first_fail`  out  3  {a,b,c} of the first mismatch.
- `first_fail_vld`  out  1  `first_fail` is meaningful.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE to RUN on `start`. All counters, `cov`, `first_fail*`, and `timeout` clear in that same edge.
- In RUN, `smp_ready`=1. A sample is accepted when `smp_valid & smp_ready`.
- `smp_ready`=0 in IDLE and DONE. Valid samples there are ignored, not queued.
- On accept:
  - `smp_cnt`++.
  - `cov[{a,b}]` set.
  - If `smp_c != TRUTH_TABLE[{a,b}]`: `err_cnt`++. If `first_fail_vld`=0, capture {a,b,c} and set `first_fail_vld`.
- Counters saturate at all-ones and never wrap.
- RUN to DONE on the accept that makes `smp_cnt` == `N_SAMPLES`.
- `pass` = (`err_cnt`==0) & (`cov`==4'hF) & !`timeout`, registered on entry to DONE.
- `start` in RUN is ignored. `start` in DONE restarts the run: clears results and goes to RUN.
- `start` coinciding with an accept in RUN is ignored; the accept is processed.
- Reset mid-run forces IDLE and abandons the run.
- Reset values: every output 0, including `smp_ready`, `busy`, `done`, `pass`, counters, `cov`, and `first_fail`.

## Timing
- `smp_ready`, `busy`, and `done` decode from the registered state only, with no combinational path from inputs.
- `start` at edge N: `busy`=1 and `smp_ready`=1 from cycle N+1.
- Accept at edge N: `smp_cnt`, `err_cnt`, `cov`, and `first_fail` update at N+1 (1-cycle latency).
- Final accept at edge N: `done`=1, `busy`=0, `pass` valid, and `smp_ready`=0, all at N+1.
- Back-to-back accepts are allowed every cycle, for a throughput of 1 sample/clk.

## Configuration
- `GATE_CHK_TIMEOUT_EN` defined:
  - A watchdog counts RUN cycles with no accept and resets on each accept.
  - When the count reaches `TIMEOUT`, the next cycle is DONE with `timeout`=1 and `pass`=0. Counters hold their values.
- `GATE_CHK_TIMEOUT_EN` undefined:
  - The watchdog is not built and `timeout` is tied 0.
  - RUN waits indefinitely for samples.

## Structure
- Package `gate_chk_pkg` holds:
  - the FSM state enum `chk_state_t`;
  - truth-table constants `TT_AND`=4'b1000, `TT_OR`=4'b1110, `TT_XOR`=4'b0110, `TT_NAND`=4'b0111.
- Sub-module `sat_counter` (parameter width, inputs clr and inc, saturating) is instantiated for `smp_cnt`, `err_cnt`, and the watchdog.
- Everything else lives in `gate_resp_checker`.

## Test plan
- AND table, `start`, then samples 00/0, 01/0, 10/0, 11/1, one per cycle: `done`=1 the cycle after the 4th; `pass`=1, `err_cnt`=0, `cov`=4'hF.
- Same run with the 3rd sample 10/1 and 4th 11/0: `err_cnt`=2, `first_fail`=3'b101, `first_fail_vld`=1, `pass`=0.
- Four samples all 11/1: `err_cnt`=0, `cov`=4'b1000, `pass`=0 (incomplete coverage).
- `N_SAMPLES`=300, `CNT_W`=8, every sample wrong: `smp_cnt` and `err_cnt` saturate at 255; no `done` until the watchdog fires (macro defined), or the run stays in RUN (macro undefined).
- Macro defined, `TIMEOUT`=8: `start`, 2 samples, then `smp_valid` low for 8 cycles → `done`=1, `timeout`=1, `pass`=0, `smp_cnt`=2.
- `rst_n` pulled low mid-run after 2 samples: all outputs 0 asynchronously. After release, `start` and 4 good samples → `pass`=1.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: shared types and truth-table constants for the gate response checker.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    // Expected gate output indexed by {a,b}
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    // Clear has priority; increment stops at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gate_resp_checker.sv
// gate_resp_checker: checks (a, b, result) samples from a 2-input gate against
// TRUTH_TABLE, counts samples/mismatches, tracks input coverage and the first
// failing vector, and gives a pass/fail verdict after N_SAMPLES accepts.
// Optional idle watchdog: define GATE_CHK_TIMEOUT_EN.
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter logic [3:0]  TRUTH_TABLE = TT_AND,
    parameter int unsigned N_SAMPLES   = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             smp_valid,
    output logic             smp_ready,
    input  logic             smp_a,
    input  logic             smp_b,
    input  logic             smp_c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] smp_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov,
    output logic [2:0]       first_fail,
    output logic             first_fail_vld
);

    chk_state_t state;

    logic       accept;
    logic       restart;
    logic       mismatch;
    logic       last_accept;
    logic       wd_fire;
    logic [1:0] ab;
    logic [3:0] cov_next;
    logic       err_zero_next;

    assign ab        = {smp_a, smp_b};
    assign busy      = (state == RUN);
    assign smp_ready = (state == RUN);
    assign done      = (state == DONE);

    assign accept   = smp_valid & (state == RUN);
    assign restart  = start & (state != RUN);
    assign mismatch = accept & (smp_c != TRUTH_TABLE[ab]);

    // Compare in 32 bits so an N_SAMPLES beyond the counter range never matches
    // a saturated count.
    assign last_accept = accept & (32'(smp_cnt) == 32'(N_SAMPLES - 1));

    // Verdict inputs as they will be after this edge, so pass can be
    // registered in the same edge as the final accept.
    assign cov_next      = cov | (4'b0001 << ab);
    assign err_zero_next = (err_cnt == '0) & ~mismatch;

    sat_counter #(.WIDTH(CNT_W)) u_smp_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (restart),
        .inc   (accept),
        .cnt   (smp_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (restart),
        .inc   (mismatch),
        .cnt   (err_cnt)
    );

`ifdef GATE_CHK_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;

    sat_counter #(.WIDTH(WD_W)) u_wd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state != RUN) | accept),
        .inc   (state == RUN),
        .cnt   (wd_cnt)
    );

    // Fires on the idle edge that brings the count to TIMEOUT
    assign wd_fire = (state == RUN) & ~accept & (32'(wd_cnt) == 32'(TIMEOUT - 1));
`else
    // No watchdog: RUN waits for samples indefinitely
    assign wd_fire = (TIMEOUT == 0) & 1'b0;
`endif

    // Run-control FSM with registered verdict, coverage and first-fail capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            cov            <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= RUN;
                        pass           <= 1'b0;
                        timeout        <= 1'b0;
                        cov            <= '0;
                        first_fail     <= '0;
                        first_fail_vld <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        cov <= cov_next;
                        if (mismatch && !first_fail_vld) begin
                            first_fail     <= {smp_a, smp_b, smp_c};
                            first_fail_vld <= 1'b1;
                        end
                    end
                    if (last_accept) begin
                        state <= DONE;
                        pass  <= err_zero_next & (cov_next == 4'hF);
                    end else if (wd_fire) begin
                        state   <= DONE;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_resp_checker.sv
// tb_gate_resp_checker: directed and randomized checks of gate_resp_checker
// against a sample-list model of the AND-gate checking rules.
module tb_gate_resp_checker;
    import gate_chk_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;

    // Main DUT: AND table, 4 samples per run, short watchdog
    logic       start, smp_valid, smp_a, smp_b, smp_c;
    logic       smp_ready, busy, done, pass, timeout, first_fail_vld;
    logic [7:0] smp_cnt, err_cnt;
    logic [3:0] cov;
    logic [2:0] first_fail;

    // Saturation DUT: run length beyond the counter range
    logic       s_start, s_valid, s_a, s_b, s_c;
    logic       s_ready, s_busy, s_done, s_pass, s_timeout, s_ffv;
    logic [7:0] s_smp_cnt, s_err_cnt;
    logic [3:0] s_cov;
    logic [2:0] s_ff;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gate_resp_checker #(
        .TRUTH_TABLE (TT_AND),
        .N_SAMPLES   (4),
        .CNT_W       (8),
        .TIMEOUT     (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .smp_valid      (smp_valid),
        .smp_ready      (smp_ready),
        .smp_a          (smp_a),
        .smp_b          (smp_b),
        .smp_c          (smp_c),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .smp_cnt        (smp_cnt),
        .err_cnt        (err_cnt),
        .cov            (cov),
        .first_fail     (first_fail),
        .first_fail_vld (first_fail_vld)
    );

    gate_resp_checker #(
        .TRUTH_TABLE (TT_AND),
        .N_SAMPLES   (300),
        .CNT_W       (8),
        .TIMEOUT     (8)
    ) dut_sat (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (s_start),
        .smp_valid      (s_valid),
        .smp_ready      (s_ready),
        .smp_a          (s_a),
        .smp_b          (s_b),
        .smp_c          (s_c),
        .busy           (s_busy),
        .done           (s_done),
        .pass           (s_pass),
        .timeout        (s_timeout),
        .smp_cnt        (s_smp_cnt),
        .err_cnt        (s_err_cnt),
        .cov            (s_cov),
        .first_fail     (s_ff),
        .first_fail_vld (s_ffv)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Drive one sample for one cycle, leaving smp_valid high for back-to-back use
    task automatic drive(input logic a, input logic b, input logic c);
        smp_valid = 1'b1;
        smp_a = a;
        smp_b = b;
        smp_c = c;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({smp_ready, busy, done, pass, timeout, smp_cnt, err_cnt, cov, first_fail, first_fail_vld} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0", {smp_ready, busy, done, pass, timeout, smp_cnt, err_cnt, cov, first_fail, first_fail_vld});
        end
        checks++;
        if ({s_ready, s_busy, s_done, s_smp_cnt, s_err_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_sat_outputs got=%b exp=0", {s_ready, s_busy, s_done, s_smp_cnt, s_err_cnt});
        end
        rst_n = 1'b1;
        cyc();
        // Samples while IDLE are ignored
        drive(1'b1, 1'b1, 1'b1);
        smp_valid = 1'b0;
        checks++;
        if (smp_cnt !== 8'd0 || smp_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore got cnt=%0d ready=%b exp cnt=0 ready=0", smp_cnt, smp_ready);
        end
    endtask

    task automatic test_and_pass();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || smp_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_latency got busy=%b ready=%b done=%b exp 1 1 0", busy, smp_ready, done);
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (smp_cnt !== 8'd1 || cov !== 4'b0001) begin
            errors++;
            $display("FAIL accept_latency got cnt=%0d cov=%b exp cnt=1 cov=0001", smp_cnt, cov);
        end
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL early_done got done=%b busy=%b exp 0 1", done, busy);
        end
        drive(1'b1, 1'b1, 1'b1);
        smp_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || smp_ready !== 1'b0) begin
            errors++;
            $display("FAIL and_done got done=%b busy=%b ready=%b exp 1 0 0", done, busy, smp_ready);
        end
        checks++;
        if (pass !== 1'b1 || err_cnt !== 8'd0 || cov !== 4'hF || smp_cnt !== 8'd4) begin
            errors++;
            $display("FAIL and_verdict got pass=%b err=%0d cov=%b cnt=%0d exp 1 0 1111 4", pass, err_cnt, cov, smp_cnt);
        end
        // Samples in DONE are ignored
        drive(1'b0, 1'b0, 1'b1);
        smp_valid = 1'b0;
        checks++;
        if (smp_cnt !== 8'd4 || err_cnt !== 8'd0 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_ignore got cnt=%0d err=%0d done=%b exp 4 0 1", smp_cnt, err_cnt, done);
        end
    endtask

    task automatic test_mismatch();
        pulse_start();
        checks++;
        if (smp_cnt !== 8'd0 || cov !== 4'd0 || pass !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear got cnt=%0d cov=%b pass=%b done=%b exp 0 0000 0 0", smp_cnt, cov, pass, done);
        end
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        smp_valid = 1'b0;
        checks++;
        if (err_cnt !== 8'd2 || first_fail !== 3'b101 || first_fail_vld !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_capture got err=%0d ff=%b vld=%b exp 2 101 1", err_cnt, first_fail, first_fail_vld);
        end
        checks++;
        if (done !== 1'b1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL mismatch_verdict got done=%b pass=%b exp 1 0", done, pass);
        end
    endtask

    task automatic test_coverage();
        pulse_start();
        for (int unsigned i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1);
        smp_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || err_cnt !== 8'd0 || cov !== 4'b1000 || pass !== 1'b0) begin
            errors++;
            $display("FAIL coverage_gap got done=%b err=%0d cov=%b pass=%b exp 1 0 1000 0", done, err_cnt, cov, pass);
        end
    endtask

    task automatic test_start_in_run();
        pulse_start();
        drive(1'b0, 1'b0, 1'b0);
        // start together with an accept: the accept counts, the start does not
        start = 1'b1;
        drive(1'b0, 1'b1, 1'b1);
        smp_valid = 1'b0;
        cyc();
        start = 1'b0;
        checks++;
        if (smp_cnt !== 8'd2 || err_cnt !== 8'd1 || busy !== 1'b1 || first_fail !== 3'b011) begin
            errors++;
            $display("FAIL start_in_run got cnt=%0d err=%0d busy=%b ff=%b exp 2 1 1 011", smp_cnt, err_cnt, busy, first_fail);
        end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        smp_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || err_cnt !== 8'd1 || cov !== 4'hF || pass !== 1'b0) begin
            errors++;
            $display("FAIL start_in_run_end got done=%b err=%0d cov=%b pass=%b exp 1 1 1111 0", done, err_cnt, cov, pass);
        end
    endtask

    task automatic test_reset_midrun();
        pulse_start();
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        smp_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({smp_ready, busy, done, pass, timeout, smp_cnt, err_cnt, cov, first_fail, first_fail_vld} !== '0) begin
            errors++;
            $display("FAIL async_reset got=%b exp=0", {smp_ready, busy, done, pass, timeout, smp_cnt, err_cnt, cov, first_fail, first_fail_vld});
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        pulse_start();
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        smp_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || smp_cnt !== 8'd4 || first_fail_vld !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_run got done=%b pass=%b cnt=%0d vld=%b exp 1 1 4 0", done, pass, smp_cnt, first_fail_vld);
        end
    endtask

    task automatic test_random();
        for (int unsigned run = 0; run < 25; run++) begin
            int         acc;
            int         nerr;
            int         gap;
            int         cycles;
            logic [3:0] mcov;
            logic [2:0] mff;
            logic       mffv;
            logic       a, b, c, v;
            acc = 0; nerr = 0; gap = 0; cycles = 0;
            mcov = 4'd0; mff = 3'd0; mffv = 1'b0;
            pulse_start();
            while (acc < 4 && cycles < 100) begin
                v = ($urandom_range(0, 3) != 0) || (gap >= 3);
                a = 1'(($urandom));
                b = 1'(($urandom));
                // Expected AND output, flipped about one time in four
                c = (a & b) ^ ($urandom_range(0, 3) == 0);
                start = (acc < 3) && ($urandom_range(0, 7) == 0);
                smp_valid = v; smp_a = a; smp_b = b; smp_c = c;
                cyc();
                cycles++;
                if (v) begin
                    acc++;
                    gap = 0;
                    mcov[{a, b}] = 1'b1;
                    if (c != (a & b)) begin
                        nerr++;
                        if (!mffv) begin
                            mff = {a, b, c};
                            mffv = 1'b1;
                        end
                    end
                end else begin
                    gap++;
                end
                checks++;
                if (smp_cnt !== 8'(acc) || done !== (acc == 4)) begin
                    errors++;
                    $display("FAIL rand_progress run=%0d got cnt=%0d done=%b exp cnt=%0d done=%b", run, smp_cnt, done, acc, acc == 4);
                end
            end
            start = 1'b0;
            smp_valid = 1'b0;
            checks++;
            if (err_cnt !== 8'(nerr) || cov !== mcov || first_fail_vld !== mffv || (mffv && first_fail !== mff)) begin
                errors++;
                $display("FAIL rand_results run=%0d got err=%0d cov=%b ff=%b vld=%b exp err=%0d cov=%b ff=%b vld=%b",
                         run, err_cnt, cov, first_fail, first_fail_vld, nerr, mcov, mff, mffv);
            end
            checks++;
            if (pass !== ((nerr == 0) && (mcov == 4'hF)) || timeout !== 1'b0) begin
                errors++;
                $display("FAIL rand_pass run=%0d got pass=%b to=%b exp pass=%b to=0", run, pass, timeout, (nerr == 0) && (mcov == 4'hF));
            end
        end
    endtask

    task automatic test_timeout();
        pulse_start();
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        smp_valid = 1'b0;
`ifdef GATE_CHK_TIMEOUT_EN
        for (int unsigned i = 0; i < 7; i++) cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early got done=%b busy=%b exp 0 1", done, busy);
        end
        cyc();
        checks++;
        if (done !== 1'b1 || timeout !== 1'b1 || pass !== 1'b0 || smp_cnt !== 8'd2) begin
            errors++;
            $display("FAIL timeout_fire got done=%b to=%b pass=%b cnt=%0d exp 1 1 0 2", done, timeout, pass, smp_cnt);
        end
        // A fresh run clears the timeout flag
        pulse_start();
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_clear got to=%b busy=%b exp 0 1", timeout, busy);
        end
        for (int unsigned i = 0; i < 8; i++) cyc();
`else
        for (int unsigned i = 0; i < 20; i++) cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || timeout !== 1'b0 || smp_cnt !== 8'd2) begin
            errors++;
            $display("FAIL no_watchdog got done=%b busy=%b to=%b cnt=%0d exp 0 1 0 2", done, busy, timeout, smp_cnt);
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
`endif
    endtask

    task automatic test_saturation();
        s_start = 1'b1;
        cyc();
        s_start = 1'b0;
        for (int unsigned i = 0; i < 260; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            s_valid = 1'b1;
            s_a = ab[1];
            s_b = ab[0];
            s_c = ~(ab[1] & ab[0]);
            cyc();
        end
        s_valid = 1'b0;
        checks++;
        if (s_smp_cnt !== 8'd255 || s_err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_counts got cnt=%0d err=%0d exp 255 255", s_smp_cnt, s_err_cnt);
        end
        checks++;
        if (s_done !== 1'b0 || s_busy !== 1'b1 || s_cov !== 4'hF || s_ff !== 3'b001) begin
            errors++;
            $display("FAIL sat_state got done=%b busy=%b cov=%b ff=%b exp 0 1 1111 001", s_done, s_busy, s_cov, s_ff);
        end
`ifdef GATE_CHK_TIMEOUT_EN
        begin
            int waited;
            waited = 0;
            while (s_done !== 1'b1 && waited < 20) begin
                cyc();
                waited++;
            end
            checks++;
            if (s_done !== 1'b1 || s_timeout !== 1'b1 || s_pass !== 1'b0 || s_smp_cnt !== 8'd255) begin
                errors++;
                $display("FAIL sat_timeout got done=%b to=%b pass=%b cnt=%0d exp 1 1 0 255", s_done, s_timeout, s_pass, s_smp_cnt);
            end
        end
`else
        for (int unsigned i = 0; i < 20; i++) cyc();
        checks++;
        if (s_done !== 1'b0 || s_busy !== 1'b1 || s_timeout !== 1'b0) begin
            errors++;
            $display("FAIL sat_hold got done=%b busy=%b to=%b exp 0 1 0", s_done, s_busy, s_timeout);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; smp_valid = 1'b0; smp_a = 1'b0; smp_b = 1'b0; smp_c = 1'b0;
        s_start = 1'b0; s_valid = 1'b0; s_a = 1'b0; s_b = 1'b0; s_c = 1'b0;
        test_reset();
        test_and_pass();
        test_mismatch();
        test_coverage();
        test_start_in_run();
        test_reset_midrun();
        test_random();
        test_timeout();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
